// File: rtl/mem_access_splitter_pkg.sv
// Shared definitions for the MEM-stage access splitter.
//   state_e        : splitter FSM states
//   F3_*           : RV32I load/store width codes (funct3)
//   lane_mask()    : width/offset -> 8-bit byte mask spanning two words
//   is_misaligned(): true when an access crosses a word boundary
package mem_access_splitter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ST2  = 2'd1,
    LD2  = 2'd2,
    LDM  = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Low nibble covers the first word, high nibble the following word.
  // Unsupported width codes produce an empty mask.
  function automatic logic [7:0] lane_mask(input logic [2:0] funct3,
                                           input logic [1:0] off);
    logic [7:0] m;
    case (funct3)
      F3_B, F3_BU: m = 8'h01;
      F3_H, F3_HU: m = 8'h03;
      F3_W:        m = 8'h0F;
      default:     m = 8'h00;
    endcase
    return m << off;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] off);
    case (funct3)
      F3_H, F3_HU: return (off == 2'b11);
      F3_W:        return (off != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_splitter_store_lane_align.sv
// Combinational store lane alignment.
//   funct3 : access width code
//   off    : byte offset within the word
//   wdata  : right-justified store data
//   mask   : 8-bit byte mask; [3:0] first beat, [7:4] second beat
//   data   : 64-bit shifted data; [31:0] first beat, [63:32] second beat
module store_lane_align
  import mem_access_splitter_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [7:0]  mask,
  output logic [63:0] data
);

  always_comb begin
    mask = lane_mask(funct3, off);
    data = {32'h0, wdata} << {off, 3'b000};
  end

endmodule

// File: rtl/mem_access_splitter.sv
// MEM-stage data access splitter. Aligned accesses pass straight through to
// RAM port A; misaligned ones are either split into two aligned beats
// (ALLOW_MISALIGN=1) or suppressed with an error pulse (ALLOW_MISALIGN=0).
//   clk, rst_n          : clock, async active-low reset
//   req_*               : access request from the pipeline (held while stalled)
//   mem_addr/wdata/we   : data RAM port A
//   mem_rdata           : synchronous RAM read data (one cycle after address)
//   stall_req           : hold the pipeline
//   ld_merged_valid/ld_merged : reassembled misaligned load word
//   misalign_err        : suppressed misaligned access
module mem_access_splitter
  import mem_access_splitter_pkg::*;
#(
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata,
  output logic        stall_req,
  output logic        ld_merged_valid,
  output logic [31:0] ld_merged,
  output logic        misalign_err
);

  state_e      state_q, state_d;
  logic [31:0] lo_q, lo_d;

  logic [1:0]  off;
  logic [31:0] base;
  logic [31:0] base_p4;
  logic        misaligned;
  logic [7:0]  st_mask;
  logic [63:0] st_data;
  logic [63:0] merged;
  logic [3:0]  we_raw;
  logic        stall_raw;
  logic        ldv_raw;
  logic        err_raw;

  store_lane_align u_align (
    .funct3 (req_funct3),
    .off    (off),
    .wdata  (req_wdata),
    .mask   (st_mask),
    .data   (st_data)
  );

  always_comb begin
    off        = req_addr[1:0];
    base       = {req_addr[31:2], 2'b00};
    base_p4    = base + 32'd4;
    misaligned = is_misaligned(req_funct3, off);
    merged     = {mem_rdata, lo_q} >> {off, 3'b000};

    state_d   = state_q;
    lo_d      = lo_q;
    mem_addr  = req_addr;
    mem_wdata = st_data[31:0];
    we_raw    = '0;
    stall_raw = 1'b0;
    ldv_raw   = 1'b0;
    err_raw   = 1'b0;
    ld_merged = merged[31:0];

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            if (ALLOW_MISALIGN) begin
              mem_addr  = base;
              stall_raw = 1'b1;
              if (req_load) begin
                state_d = LD2;
              end else begin
                we_raw  = st_mask[3:0];
                state_d = ST2;
              end
            end else begin
              err_raw = 1'b1;
            end
          end else if (!req_load) begin
            we_raw = st_mask[3:0];
          end
        end
      end
      ST2: begin
        mem_addr  = base_p4;
        mem_wdata = st_data[63:32];
        we_raw    = st_mask[7:4];
        state_d   = IDLE;
      end
      LD2: begin
        lo_d      = mem_rdata;
        mem_addr  = base_p4;
        stall_raw = 1'b1;
        state_d   = LDM;
      end
      LDM: begin
        mem_addr = base_p4;
        ldv_raw  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // While reset is held the block must look idle even if a request is
    // still presented, so the action outputs are qualified by rst_n.
    mem_we          = rst_n ? we_raw : 4'b0000;
    stall_req       = stall_raw & rst_n;
    ld_merged_valid = ldv_raw & rst_n;
    misalign_err    = err_raw & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mem_access_splitter.sv
module tb_mem_access_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem_addr, mem_wdata, ld_merged;
  logic [3:0]  mem_we;
  logic        stall_req, ld_merged_valid, misalign_err;

  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_we;
  logic        e_stall, e_ldv, e_err;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_access_splitter #(.ALLOW_MISALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_load(req_load), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall_req(stall_req),
    .ld_merged_valid(ld_merged_valid), .ld_merged(ld_merged),
    .misalign_err(misalign_err)
  );

  mem_access_splitter #(.ALLOW_MISALIGN(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_load(req_load), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(e_addr), .mem_wdata(e_wdata), .mem_we(e_we),
    .mem_rdata(mem_rdata), .stall_req(e_stall),
    .ld_merged_valid(e_ldv), .ld_merged(e_ld),
    .misalign_err(e_err)
  );

  // Read-only RAM contents for the addresses the loads touch.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a[31:2])
      30'h00000040: return 32'h44332211;
      30'h00000041: return 32'h88776655;
      30'h3FFFFFFF: return 32'hDDCCBBAA;
      30'h00000000: return 32'h12345678;
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) mem_rdata <= rom(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_load   = ld;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h11223344);
    #3;
    chk("rst_err_forced_low", 32'(e_err), 32'h0);
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    chk("rst_ldv", 32'(ld_merged_valid), 32'h0);
    chk("rst_lo_zero", ld_merged, 32'h0);
    #8 rst_n = 1'b1;

    // Aligned SW
    tick(); drive(1'b1, 1'b0, 3'b010, 32'h100, 32'hAABBCCDD); #2;
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_we", 32'(mem_we), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hAABBCCDD);
    chk("sw_stall", 32'(stall_req), 32'h0);
    chk("e_sw_we", 32'(e_we), 32'hF);
    chk("e_sw_err", 32'(e_err), 32'h0);

    // SB at offset 3
    tick(); drive(1'b1, 1'b0, 3'b000, 32'h203, 32'h000000EE); #2;
    chk("sb_we", 32'(mem_we), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hEE000000);
    chk("sb_stall", 32'(stall_req), 32'h0);

    // Aligned SH at offset 2
    tick(); drive(1'b1, 1'b0, 3'b001, 32'h302, 32'h0000BEEF); #2;
    chk("sh_we", 32'(mem_we), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEF0000);
    chk("sh_stall", 32'(stall_req), 32'h0);

    // Aligned load: no write
    tick(); drive(1'b1, 1'b1, 3'b010, 32'h104, 32'hFFFFFFFF); #2;
    chk("lw_al_we", 32'(mem_we), 32'h0);
    chk("lw_al_stall", 32'(stall_req), 32'h0);

    // Misaligned SW @0x102
    tick(); drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h11223344); #2;
    chk("msw_t_addr", mem_addr, 32'h100);
    chk("msw_t_we", 32'(mem_we), 32'hC);
    chk("msw_t_wdata", mem_wdata, 32'h33440000);
    chk("msw_t_stall", 32'(stall_req), 32'h1);
    chk("e_msw_err", 32'(e_err), 32'h1);
    chk("e_msw_we", 32'(e_we), 32'h0);
    chk("e_msw_stall", 32'(e_stall), 32'h0);
    tick(); #2;
    chk("msw_t1_addr", mem_addr, 32'h104);
    chk("msw_t1_we", 32'(mem_we), 32'h3);
    chk("msw_t1_wdata", mem_wdata, 32'h00001122);
    chk("msw_t1_stall", 32'(stall_req), 32'h0);

    // Idle
    tick(); drive(1'b0, 1'b0, 3'b010, 32'h102, 32'h11223344); #2;
    chk("idle_we", 32'(mem_we), 32'h0);
    chk("idle_stall", 32'(stall_req), 32'h0);
    chk("idle_ldv", 32'(ld_merged_valid), 32'h0);
    chk("e_idle_err", 32'(e_err), 32'h0);

    // Misaligned LW @0x101
    tick(); drive(1'b1, 1'b1, 3'b010, 32'h101, 32'h0); #2;
    chk("mlw_t_addr", mem_addr, 32'h100);
    chk("mlw_t_stall", 32'(stall_req), 32'h1);
    chk("mlw_t_we", 32'(mem_we), 32'h0);
    chk("e_mlw_err", 32'(e_err), 32'h1);
    chk("e_mlw_stall", 32'(e_stall), 32'h0);
    tick(); #2;
    chk("mlw_t1_addr", mem_addr, 32'h104);
    chk("mlw_t1_stall", 32'(stall_req), 32'h1);
    chk("mlw_t1_ldv", 32'(ld_merged_valid), 32'h0);
    tick(); #2;
    chk("mlw_t2_ldv", 32'(ld_merged_valid), 32'h1);
    chk("mlw_t2_data", ld_merged, 32'h55443322);
    chk("mlw_t2_stall", 32'(stall_req), 32'h0);
    tick(); drive(1'b0, 1'b1, 3'b010, 32'h0, 32'h0); #2;
    chk("mlw_done_ldv", 32'(ld_merged_valid), 32'h0);

    // Misaligned LH @0xFFFFFFFF wraps to word 0
    tick(); drive(1'b1, 1'b1, 3'b001, 32'hFFFFFFFF, 32'h0); #2;
    chk("wrap_t_addr", mem_addr, 32'hFFFFFFFC);
    chk("wrap_t_stall", 32'(stall_req), 32'h1);
    tick(); #2;
    chk("wrap_t1_addr", mem_addr, 32'h00000000);
    chk("wrap_t1_stall", 32'(stall_req), 32'h1);
    tick(); #2;
    chk("wrap_t2_ldv", 32'(ld_merged_valid), 32'h1);
    chk("wrap_t2_data", ld_merged, 32'h345678DD);
    tick(); drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); #2;

    // Misaligned SH @0x103
    tick(); drive(1'b1, 1'b0, 3'b001, 32'h103, 32'h0000ABCD); #2;
    chk("msh_t_addr", mem_addr, 32'h100);
    chk("msh_t_we", 32'(mem_we), 32'h8);
    chk("msh_t_wdata", mem_wdata, 32'hCD000000);
    tick(); #2;
    chk("msh_t1_addr", mem_addr, 32'h104);
    chk("msh_t1_we", 32'(mem_we), 32'h1);
    chk("msh_t1_wdata", mem_wdata, 32'h000000AB);
    tick(); drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); #2;

    // Reset during LD2, then aligned LW
    tick(); drive(1'b1, 1'b1, 3'b010, 32'h101, 32'h0); #2;
    tick();
    chk("rl_ld2_stall", 32'(stall_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rl_stall", 32'(stall_req), 32'h0);
    chk("rl_ldv", 32'(ld_merged_valid), 32'h0);
    drive(1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
    #1;
    rst_n = 1'b1;
    tick(); drive(1'b1, 1'b1, 3'b010, 32'h104, 32'h0); #2;
    chk("rl_lw_addr", mem_addr, 32'h104);
    chk("rl_lw_stall", 32'(stall_req), 32'h0);
    chk("rl_lw_we", 32'(mem_we), 32'h0);
    chk("rl_lw_ldv", 32'(ld_merged_valid), 32'h0);
    chk("rl_lo_cleared", ld_merged, 32'h0);
    tick(); drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); #2;
    chk("rl_after_stall", 32'(stall_req), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_splitter.md
MEM_ACCESS_SPLITTER -- requirements
Module: mem_access_splitter

Interface
REQ-001 Parameter ALLOW_MISALIGN, default 1; 1 means split misaligned accesses into two aligned beats, 0 means suppress them and flag an error.
REQ-002 One clock; reset is asynchronous and active-low (ports clk and rst_n).
REQ-003 clk  input  1  pipeline clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  MEM-stage access present this cycle.
REQ-006 req_load  input  1  1 means load, 0 means store; meaningful only with req_valid.
REQ-007 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 mem_addr  output  32  byte address to data RAM port A; RAM uses mem_addr[31:2].
REQ-011 mem_wdata  output  32  lane-aligned store data.
REQ-012 mem_we  output  4  byte write enables; bit i writes byte lane i.
REQ-013 mem_rdata  input  32  raw synchronous RAM read data, valid one cycle after mem_addr.
REQ-014 stall_req  output  1  holds the pipeline; the upstream holds all req_* stable while it is 1.
REQ-015 ld_merged_valid  output  1  ld_merged replaces RAM data this cycle, with byte offset treated as 0.
REQ-016 ld_merged  output  32  reassembled misaligned load word, unextended.
REQ-017 misalign_err  output  1  one-cycle pulse for a suppressed misaligned access (ALLOW_MISALIGN=0).

Function
REQ-018 The access is misaligned when H/HU has addr[1:0]=11, or when W has addr[1:0]!=00; B/BU is never misaligned.
REQ-019 Aligned access, state IDLE: mem_addr=req_addr; store WE is 0001<<off (B), 0011<<off (H) or 1111 (W); mem_wdata=req_wdata<<(8*off); stall_req=0; zero added latency.
REQ-020 Load, or req_valid=0: mem_we=0000.
REQ-021 FSM states IDLE, ST2, LD2, LDM; encoding lives in the package.
REQ-022 Misaligned store, cycle T (IDLE): mem_addr={addr[31:2],00}; mem_we holds the width mask shifted left by off, truncated to 4 bits; mem_wdata=req_wdata<<(8*off); stall_req=1; next state ST2.
REQ-023 ST2, cycle T+1: mem_addr=base+4; mem_we holds the mask bits shifted out of beat 1; mem_wdata=req_wdata>>(8*(4-off)); stall_req=0; next state IDLE.
REQ-024 Misaligned load, cycle T: mem_addr=base; stall_req=1; next state LD2.
REQ-025 LD2, cycle T+1: register mem_rdata as lo; mem_addr=base+4; stall_req=1; next state LDM.
REQ-026 LDM, cycle T+2: ld_merged=({mem_rdata,lo}>>(8*off))[31:0]; ld_merged_valid=1; stall_req=0; next state IDLE.
REQ-027 base+4 wraps modulo 2^32, so 0xFFFFFFFE with W uses word addresses 0xFFFFFFFC then 0x00000000.
REQ-028 With ALLOW_MISALIGN=0, a misaligned request drives mem_we=0000 and pulses misalign_err for one cycle; FSM stays IDLE and stall_req=0.
REQ-029 In ST2/LD2/LDM the block ignores req_valid changes; a new request is accepted only in IDLE.
REQ-030 Outputs in IDLE with req_valid=0: mem_we=0, stall_req=0, ld_merged_valid=0, misalign_err=0.

Reset
REQ-031 rst_n low forces state IDLE, lo=0 and misalign_err=0 immediately, regardless of clk.
REQ-032 Reset mid-split abandons the access; any beat-1 store already written stays written.
REQ-033 First access is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-034 The shared package holds the FSM state enum, the funct3 width constants, and a lane-mask function (width, off) -> 8-bit mask.
REQ-035 The sole sub-module is store_lane_align (combinational: funct3, off, wdata -> 8-bit mask, 64-bit shifted data); beat 1 uses the low halves, beat 2 the high halves.
REQ-036 All outputs are combinational from state and req_*; only state and lo are registered.

Verification
REQ-037 SW 0xAABBCCDD @0x100 -> one cycle: mem_addr=0x100, we=1111, wdata=0xAABBCCDD, stall_req=0.
REQ-038 SB 0x000000EE @0x203 -> we=1000, wdata=0xEE000000, no stall.
REQ-039 SW 0x11223344 @0x102 -> T: addr 0x100, we=1100, wdata=0x33440000, stall=1; T+1: addr 0x104, we=0011, wdata=0x00001122, stall=0.
REQ-040 LW @0x101, RAM[0x100]=0x44332211, RAM[0x104]=0x88776655 -> at T+2 ld_merged=0x55443322, ld_merged_valid=1; stall high for T and T+1.
REQ-041 LH @0xFFFFFFFF, ALLOW_MISALIGN=1 -> beats at word addresses 0xFFFFFFFC and 0x00000000 (wrap).
REQ-042 rst_n low during LD2 -> state IDLE and stall_req=0 at once; a following aligned LW completes normally.
